screen_write_arbiter: RTL and testbench

//  Owns the single write port of the 40x30 character screen memory read by the VGA display driver.

---
 rtl/screen_write_arbiter.sv | 110 +++++++++++
 tb/tb_screen_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_write_arbiter.sv
// Single write port owner for the 40x30 character screen memory: round-robin between CPU stores and a fill engine.
// Optional build macro FILL_BLANK_ONLY_EN restricts fill writes to blanking intervals (active_video=0).
module screen_write_arbiter #(
  parameter int CELLS = 1200,
  parameter int AW    = 11,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_code,
  input  logic          active_video,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          scr_we,
  output logic [AW-1:0] scr_addr,
  output logic [DW-1:0] scr_wdata
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state_reg;
  logic [AW-1:0] count_reg;
  logic [DW-1:0] code_reg;
  logic          last_cpu_reg;   // 1: CPU won the most recent contended cycle

  logic fill_ok;
  logic cpu_elig;
  logic fill_elig;
  logic grant_cpu;
  logic grant_fill;

`ifdef FILL_BLANK_ONLY_EN
  assign fill_ok = ~active_video;
`else
  logic unused_active_video;
  assign unused_active_video = active_video;
  assign fill_ok = 1'b1;
`endif

  // A request is not re-counted in the cycle its ack is visible, so one request yields one grant.
  always_comb begin
    cpu_elig   = cpu_req & ~cpu_ack;
    fill_elig  = (state_reg == FILL) & fill_ok;
    grant_cpu  = cpu_elig & ~(fill_elig & last_cpu_reg);
    grant_fill = fill_elig & ~(cpu_elig & ~last_cpu_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      code_reg     <= '0;
      last_cpu_reg <= 1'b0;
      cpu_ack      <= 1'b0;
      fill_busy    <= 1'b0;
      fill_done    <= 1'b0;
      scr_we       <= 1'b0;
      scr_addr     <= '0;
      scr_wdata    <= '0;
    end else begin
      cpu_ack   <= grant_cpu;
      scr_we    <= 1'b0;
      fill_done <= 1'b0;

      if (cpu_elig && fill_elig)
        last_cpu_reg <= grant_cpu;

      if (grant_fill) begin
        scr_we    <= 1'b1;
        scr_addr  <= count_reg;
        scr_wdata <= code_reg;
        count_reg <= count_reg + 1'b1;
      end else if (grant_cpu) begin
        scr_wdata <= cpu_wdata;
        // Out-of-range stores are acked but dropped so the CPU never hangs.
        if (cpu_addr < AW'(CELLS)) begin
          scr_we   <= 1'b1;
          scr_addr <= cpu_addr;
        end
      end

      case (state_reg)
        IDLE: begin
          if (fill_start) begin
            code_reg  <= fill_code;
            count_reg <= '0;
            fill_busy <= 1'b1;
            state_reg <= FILL;
          end
        end
        FILL: begin
          if (grant_fill && count_reg == AW'(CELLS - 1))
            state_reg <= DONE;
        end
        DONE: begin
          fill_done <= 1'b1;
          fill_busy <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Randomized and directed bench for screen_write_arbiter against a cycle-level behavioural model.
// Honours FILL_BLANK_ONLY_EN when the build defines it.
module tb_screen_write_arbiter;

  localparam int CELLS = 1200;
  localparam int AW    = 11;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          fill_start;
  logic [DW-1:0] fill_code;
  logic          active_video;
  logic          fill_busy;
  logic          fill_done;
  logic          scr_we;
  logic [AW-1:0] scr_addr;
  logic [DW-1:0] scr_wdata;

  screen_write_arbiter #(.CELLS(CELLS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .fill_start(fill_start), .fill_code(fill_code), .active_video(active_video),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .scr_we(scr_we), .scr_addr(scr_addr), .scr_wdata(scr_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;
  int n_ack = 0;
  int mode  = 0;   // 0 directed, 1 CPU always requesting, 2 random

  // Model state: expected outputs plus the fill engine's progress.
  logic          e_ack, e_busy, e_done, e_we, e_fillwr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            m_fill_on, m_done_pending, m_last_cpu;
  int            m_next;
  logic [DW-1:0] m_code;
  int            hits [CELLS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_ack = 0; e_busy = 0; e_done = 0; e_we = 0; e_fillwr = 0;
    e_addr = '0; e_wdata = '0;
    m_fill_on = 0; m_done_pending = 0; m_last_cpu = 0; m_next = 0; m_code = '0;
    for (int i = 0; i < CELLS; i++) hits[i] = 0;
  endtask

  // Predicts the outputs visible after the coming rising edge from the current inputs.
  task automatic model_edge();
    bit cpu_e, fill_e, gc, gf, allowed, was_busy;
    if (!rst_n) return;
    allowed = 1;
`ifdef FILL_BLANK_ONLY_EN
    allowed = !active_video;
`endif
    was_busy = e_busy;
    cpu_e  = cpu_req && !e_ack;
    fill_e = m_fill_on && allowed;
    if (cpu_e && fill_e) begin
      gc = !m_last_cpu;
      gf = m_last_cpu;
      m_last_cpu = gc;
    end else begin
      gc = cpu_e;
      gf = fill_e;
    end
    e_done = 0;
    if (m_done_pending) begin
      e_done = 1; e_busy = 0; m_done_pending = 0;
    end
    e_ack = gc; e_we = 0; e_fillwr = 0;
    if (gf) begin
      e_we = 1; e_fillwr = 1; e_addr = AW'(m_next); e_wdata = m_code;
      m_next++;
      if (m_next == CELLS) begin
        m_fill_on = 0; m_done_pending = 1;
      end
    end else if (gc) begin
      e_wdata = cpu_wdata;
      if (int'(cpu_addr) < CELLS) begin
        e_we = 1; e_addr = cpu_addr;
      end
    end
    if (fill_start && !was_busy) begin
      m_fill_on = 1; m_next = 0; m_code = fill_code; e_busy = 1;
    end
  endtask

  task automatic compare_outputs();
    int bad;
    check("outs", {cpu_ack, fill_busy, fill_done, scr_we, scr_addr, scr_wdata},
                  {e_ack, e_busy, e_done, e_we, e_addr, e_wdata});
    if (cpu_ack) begin
      n_ack++;
      $display("cpu txn addr=%0d data=%0h we=%0b", cpu_addr, cpu_wdata, scr_we);
    end
    if (scr_we && e_fillwr && int'(scr_addr) < CELLS) hits[scr_addr]++;
    if (e_done) begin
      bad = 0;
      for (int i = 0; i < CELLS; i++) begin
        if (hits[i] != 1) bad++;
        hits[i] = 0;
      end
      check("fill_cover", bad, 0);
      $display("fill done code=%0h bad_cells=%0d", m_code, bad);
    end
  endtask

  task automatic new_request(input bit allow_oor);
    cpu_req = 1;
    if (allow_oor && $urandom_range(0, 9) == 0) cpu_addr = AW'(CELLS + $urandom_range(0, 847));
    else cpu_addr = AW'($urandom_range(0, CELLS - 1));
    cpu_wdata = DW'($urandom);
    n_req++;
  endtask

  task automatic drive_inputs();
    fill_start = 0;
    case (mode)
      1: if (!cpu_req || e_ack) new_request(0);
      2: begin
        if (!cpu_req || e_ack) begin
          if ($urandom_range(0, 3) != 0) new_request(1);
          else cpu_req = 0;
        end
        if ($urandom_range(0, 299) == 0) begin
          fill_start = 1; fill_code = DW'($urandom);
        end
        if ($urandom_range(0, 7) == 0) active_video = ~active_video;
      end
      default: if (e_ack) cpu_req = 0;
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs();
    drive_inputs();
  endtask

  task automatic start_fill(input logic [DW-1:0] code);
    fill_code = code; fill_start = 1;
    step();
  endtask

  task automatic run_to_done(input string tag, input int limit);
    int k = 0;
    while (!e_done && k < limit) begin
      step(); k++;
    end
    check(tag, fill_done, 1);
  endtask

  initial begin
    int w;
    int k;
    rst_n = 0; cpu_req = 0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 0; fill_code = '0; active_video = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {cpu_ack, fill_busy, fill_done, scr_we, scr_addr, scr_wdata}, 0);
    rst_n = 1;

    // Single uncontended CPU store.
    cpu_req = 1; cpu_addr = 11'd5; cpu_wdata = 4'hA;
    step();
    check("t1_ack", cpu_ack, 1);
    check("t1_we", scr_we, 1);
    check("t1_addr", scr_addr, 5);
    check("t1_wdata", scr_wdata, 4'hA);
    step();
    check("t1_single", {cpu_ack, scr_we}, 0);

    // Uncontended fill.
    start_fill(4'h3);
    w = 0; k = 0;
    while (!e_done && k < 1300) begin
      step(); k++;
      if (scr_we) w++;
    end
    check("t2_done", fill_done, 1);
    check("t2_writes", w, CELLS);

    // Fill with the CPU requesting every cycle it can.
    n_req = 0; n_ack = 0;
    mode = 1;
    start_fill(4'h7);
    run_to_done("t3_done", 3000);
    mode = 0;
    repeat (4) step();
    check("t3_req_ack", n_ack, n_req);

    // Out-of-range store and ignored restart mid-fill.
    start_fill(4'h5);
    repeat (10) step();
    fill_code = 4'h9; fill_start = 1;
    cpu_req = 1; cpu_addr = 11'd1200; cpu_wdata = 4'h7;
    k = 0;
    do begin step(); k++; end while (!cpu_ack && k < 5);
    check("t4_ack", cpu_ack, 1);
    check("t4_oor_we", scr_we, 0);
    run_to_done("t4_done", 1300);
    repeat (3) step();
    check("t4_norestart", fill_busy, 0);

    // Asynchronous reset mid-fill.
    start_fill(4'h6);
    k = 0;
    while (m_next < 600 && k < 700) begin step(); k++; end
    check("t5_reached600", m_next, 600);
    #2;
    rst_n = 0;
    #1;
    check("t5_async", {cpu_ack, fill_busy, fill_done, scr_we, scr_addr, scr_wdata}, 0);
    model_reset();
    repeat (2) step();
    rst_n = 1;
    start_fill(4'h2);
    step();
    check("t5_restart_addr", {scr_we, scr_addr}, {1'b1, 11'd0});
    run_to_done("t5_done", 1300);

    // Fill while active video is high for 100 cycles.
    start_fill(4'h1);
    repeat (50) step();
    active_video = 1;
    w = 0;
    repeat (100) begin step(); if (scr_we) w++; end
    active_video = 0;
`ifdef FILL_BLANK_ONLY_EN
    check("t6_held_writes", w, 0);
`else
    check("t6_held_writes", w, 100);
`endif
    run_to_done("t6_done", 1400);

    // Randomized traffic.
    mode = 2;
    repeat (4000) step();
    mode = 0;
    active_video = 0;
    k = 0;
    while ((cpu_req || e_busy) && k < 3000) begin step(); k++; end
    check("rand_drain", {cpu_req, fill_busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
